// File: rtl/frodo_mac_pkg.sv
// rtl/frodo_mac_pkg.sv - shared constants and FSM state encoding for the Frodo MAC lanes
package frodo_mac_pkg;

  localparam int Q_BITS_640 = 15;
  localparam int Q_BITS_976 = 16;
  localparam int S_BITS_DEF = 5;
  localparam int N_LEN_640  = 640;

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t ACC  = 1'b1;

endpackage

// File: rtl/frodo_mul_lane.sv
// rtl/frodo_mul_lane.sv - one lane's unsigned-by-signed product, truncated mod 2^Q_BITS
module frodo_mul_lane
  import frodo_mac_pkg::*;
#(
  parameter int Q_BITS = Q_BITS_976,
  parameter int S_BITS = S_BITS_DEF
) (
  input  logic [Q_BITS-1:0] a,
  input  logic [S_BITS-1:0] s,
  output logic [Q_BITS-1:0] p
);

  // Only the low Q_BITS survive, so a Q x Q multiply by the sign-extended sample is exact.
  logic [Q_BITS-1:0] s_ext;

  assign s_ext = {{(Q_BITS - S_BITS){s[S_BITS-1]}}, s};
  assign p     = a * s_ext;

endmodule

// File: rtl/frodo_mac_lanes.sv
// rtl/frodo_mac_lanes.sv - multi-lane pipelined a*s+c inner-product engine with length check
module frodo_mac_lanes
  import frodo_mac_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int Q_BITS = Q_BITS_976,
  parameter int S_BITS = S_BITS_DEF,
  parameter int N_LEN  = N_LEN_640,
  parameter int CNT_W  = 11
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [LANES*Q_BITS-1:0] in_a,
  input  logic [LANES*S_BITS-1:0] in_s,
  input  logic [LANES*Q_BITS-1:0] in_c,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*Q_BITS-1:0] out_data,
  output logic                    out_len_err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W:0]   N_LEN_W  = (CNT_W + 1)'(N_LEN);
  localparam logic [CNT_W:0]   ONE_W    = (CNT_W + 1)'(1);

  typedef logic [LANES-1:0][Q_BITS-1:0] lanes_t;

  logic   advance, accept, s2_fire;
  logic   ready_en_q, ready_en_d;
  lanes_t prod;

  logic   s1_valid_q, s1_valid_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  lanes_t s1_p_q, s1_p_d, s1_c_q, s1_c_d;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  lanes_t           acc_q, acc_d, acc_sum;
  lanes_t           out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d, out_len_err_q, out_len_err_d;
  logic             open_new, proto_err, len_bad;

  assign advance     = !(out_valid_q && !out_ready);
  assign in_ready    = ready_en_q && advance;
  assign accept      = in_valid && in_ready;
  assign s2_fire     = advance && s1_valid_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_len_err = out_len_err_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    frodo_mul_lane #(
      .Q_BITS(Q_BITS),
      .S_BITS(S_BITS)
    ) u_mul (
      .a(in_a[k*Q_BITS +: Q_BITS]),
      .s(in_s[k*S_BITS +: S_BITS]),
      .p(prod[k])
    );
  end

  always_comb begin
    ready_en_d = 1'b1;
    s1_valid_d = s1_valid_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    s1_p_d     = s1_p_q;
    s1_c_d     = s1_c_q;
    if (advance) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_first_d = in_first;
        s1_last_d  = in_last;
        s1_p_d     = prod;
        s1_c_d     = in_c;
      end
    end
  end

  // A beat opens a new vector when flagged first or when nothing is open (protocol error).
  always_comb begin
    open_new  = (state_q == IDLE) || s1_first_q;
    proto_err = (state_q == IDLE) ? !s1_first_q : s1_first_q;
    for (int k = 0; k < LANES; k++) begin
      acc_sum[k] = (open_new ? s1_c_q[k] : acc_q[k]) + s1_p_q[k];
    end
    // A saturated counter means the vector already exceeds any representable length.
    len_bad = open_new ? (N_LEN_W != ONE_W)
                       : ((cnt_q == CNT_MAX) || (({1'b0, cnt_q} + ONE_W) != N_LEN_W));
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    acc_d         = acc_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    out_len_err_d = out_len_err_q;
    if (advance) out_valid_d = 1'b0;
    if (s2_fire) begin
      acc_d = acc_sum;
      if (s1_last_q) begin
        out_valid_d   = 1'b1;
        out_data_d    = acc_sum;
        out_len_err_d = (state_q == IDLE && s1_first_q) ? 1'b0 : (len_bad || proto_err || err_q);
        state_d       = IDLE;
        cnt_d         = '0;
        err_d         = 1'b0;
      end else begin
        state_d = ACC;
        cnt_d   = open_new ? CNT_W'(1) : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1));
        err_d   = err_q || proto_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready_en_q    <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_first_q    <= 1'b0;
      s1_last_q     <= 1'b0;
      s1_p_q        <= '0;
      s1_c_q        <= '0;
      state_q       <= IDLE;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      acc_q         <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_len_err_q <= 1'b0;
    end else begin
      ready_en_q    <= ready_en_d;
      s1_valid_q    <= s1_valid_d;
      s1_first_q    <= s1_first_d;
      s1_last_q     <= s1_last_d;
      s1_p_q        <= s1_p_d;
      s1_c_q        <= s1_c_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      acc_q         <= acc_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_len_err_q <= out_len_err_d;
    end
  end

endmodule

// File: tb/tb_frodo_mac_lanes.sv
// tb/tb_frodo_mac_lanes.sv - self-checking bench for frodo_mac_lanes against a vector-level model
module tb_frodo_mac_lanes;

  localparam int LANES = 4;
  localparam int QB    = 16;
  localparam int SB    = 5;
  localparam int NL    = 4;
  localparam int CW    = 3;

  typedef logic [LANES*QB:0] res_t;

  logic                clk = 1'b0;
  logic                rstn;
  logic                in_valid, in_ready, in_first, in_last;
  logic                out_valid, out_ready, out_len_err;
  logic [LANES*QB-1:0] in_a, in_c, out_data;
  logic [LANES*SB-1:0] in_s;

  int checks   = 0;
  int failures = 0;

  res_t          exp_q[$];
  res_t          obs_q[$];
  bit            m_open;
  int            m_cnt;
  bit            m_err;
  logic [QB-1:0] m_sum[LANES];

  always #5 clk = ~clk;

  frodo_mac_lanes #(
    .LANES(LANES), .Q_BITS(QB), .S_BITS(SB), .N_LEN(NL), .CNT_W(CW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
    .in_a(in_a), .in_s(in_s), .in_c(in_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_len_err(out_len_err)
  );

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [QB-1:0] lane_prod(input logic [QB-1:0] a, input logic [SB-1:0] s);
    longint pr;
    pr = longint'(a) * longint'($signed(s));
    return pr[QB-1:0];
  endfunction

  // Vector-level reference: true beat count, sticky protocol error, modular sums.
  function automatic void model_beat();
    bit   starts, perr, single;
    res_t e;
    starts = in_first || !m_open;
    perr   = (in_first == m_open);
    single = in_first && in_last && !m_open;
    for (int k = 0; k < LANES; k++) begin
      logic [QB-1:0] p;
      p = lane_prod(in_a[k*QB +: QB], in_s[k*SB +: SB]);
      m_sum[k] = starts ? in_c[k*QB +: QB] + p : m_sum[k] + p;
    end
    if (starts) begin
      m_cnt = 1;
      m_err = perr;
    end else begin
      m_cnt++;
    end
    m_open = 1'b1;
    if (in_last) begin
      for (int k = 0; k < LANES; k++) e[k*QB +: QB] = m_sum[k];
      e[LANES*QB] = single ? 1'b0 : (m_err || m_cnt != NL);
      exp_q.push_back(e);
      m_open = 1'b0;
    end
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        m_open = 1'b0;
        m_cnt  = 0;
        m_err  = 1'b0;
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) obs_q.push_back({out_len_err, out_data});
        if (in_valid && in_ready) model_beat();
      end
    end
  end

  task automatic send_beat(input logic [63:0] a, input logic [19:0] s, input logic [63:0] c,
                           input bit f, input bit l, output int waited);
    bit took;
    in_valid = 1'b1; in_a = a; in_s = s; in_c = c; in_first = f; in_last = l;
    waited = 0;
    do begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk); #1;
      waited++;
    end while (!took && waited < 100);
    in_valid = 1'b0;
    if (!took) begin
      checks++; failures++;
      $display("FAIL send_timeout waited=%0d cycles without in_ready", waited);
    end
  endtask

  task automatic send_vec(input int len, input bit f0, input int refirst);
    int w;
    for (int i = 0; i < len; i++)
      send_beat(rnd64(), 20'($urandom), rnd64(), (i == 0 && f0) || i == refirst, i == len - 1, w);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, out_len_err, out_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b vld=%b err=%b data=%h want all zero",
               in_ready, out_valid, out_len_err, out_data);
    end
    rstn = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_ready got=%b want=0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_edge_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_single();
    logic [QB-1:0] la[3], lc[3], want[3];
    logic [SB-1:0] ls[3];
    logic [63:0]   a, c;
    logic [19:0]   s;
    int            w;
    res_t          o, e;
    la = '{16'h1234, 16'hFFFF, 16'h8000};
    ls = '{5'h1D, 5'h0F, 5'h10};
    lc = '{16'h0010, 16'h0001, 16'h0000};
    want = '{16'hC974, 16'hFFF2, 16'h0000};
    obs_q.delete();
    for (int i = 0; i < 3; i++) begin
      a = rnd64(); a[15:0] = la[i];
      c = rnd64(); c[15:0] = lc[i];
      s = 20'($urandom); s[4:0] = ls[i];
      send_beat(a, s, c, 1'b1, 1'b1, w);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL single_t1_%0d got out_valid=%b want 0", i, out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data[15:0] !== want[i] || out_len_err !== 1'b0) begin
        failures++;
        $display("FAIL single_t2_%0d got vld=%b lane0=%h err=%b want vld=1 lane0=%h err=0",
                 i, out_valid, out_data[15:0], out_len_err, want[i]);
      end
      @(posedge clk); #1;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL single_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL single_model got=%h want=%h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_accumulate();
    logic [63:0] a, c;
    logic [19:0] s;
    int          w;
    res_t        o, e;
    c = rnd64(); c[15:0] = 16'd100;
    for (int i = 0; i < 4; i++) begin
      a = rnd64(); a[15:0] = 16'(i + 1);
      s = 20'($urandom); s[4:0] = 5'd1;
      send_beat(a, s, (i == 0) ? c : rnd64(), i == 0, i == 3, w);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL acc_no_early_out beat=%0d got out_valid=%b want 0", i, out_valid);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data[15:0] !== 16'h006E || out_len_err !== 1'b0) begin
      failures++;
      $display("FAIL acc_result got vld=%b lane0=%h err=%b want vld=1 lane0=006e err=0",
               out_valid, out_data[15:0], out_len_err);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL acc_single_pulse got out_valid=%b want 0", out_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      failures++;
      $display("FAIL acc_count got=%0d want=1 (model=%0d)", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL acc_model got=%h want=%h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_len_err();
    int   lens[6], refs[6];
    bit   f0s[6], want_err[6];
    res_t o, e;
    lens = '{3, 4, 4, 6, 12, 4};
    f0s  = '{1, 1, 0, 1, 1, 1};
    refs = '{-1, -1, -1, 2, -1, -1};
    want_err = '{1, 0, 1, 1, 1, 0};
    for (int i = 0; i < 6; i++) send_vec(lens[i], f0s[i], refs[i]);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != 6) begin
      failures++;
      $display("FAIL len_count got=%0d want=6", obs_q.size());
    end
    for (int i = 0; i < 6 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o[LANES*QB] !== want_err[i]) begin
        failures++;
        $display("FAIL len_err_flag vec=%0d got=%b want=%b", i, o[LANES*QB], want_err[i]);
      end
      checks++;
      if (o !== e) begin failures++; $display("FAIL len_model vec=%0d got=%h want=%h", i, o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [63:0] held, a2, c2;
    logic [19:0] s2;
    int          w;
    bit          done;
    res_t        o, e;
    out_ready = 1'b0;
    send_beat(rnd64(), 20'($urandom), rnd64(), 1'b1, 1'b1, w);
    @(posedge clk); #1;
    held = out_data;
    a2 = rnd64(); s2 = 20'($urandom); c2 = rnd64();
    in_valid = 1'b1; in_a = a2; in_s = s2; in_c = c2; in_first = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got rdy=%b vld=%b data=%h want rdy=0 vld=1 data=%h",
                 i, in_ready, out_valid, out_data, held);
      end
    end
    out_ready = 1'b1;
    send_beat(a2, s2, c2, 1'b1, 1'b1, w);
    checks++;
    if (w != 1) begin failures++; $display("FAIL bp_release_wait got=%0d want=1", w); end
    for (int i = 0; i < 16; i++) begin
      send_beat(rnd64(), 20'($urandom), rnd64(), 1'b1, 1'b1, w);
      checks++;
      if (w != 1) begin failures++; $display("FAIL bp_stream_wait beat=%0d got=%0d want=1", i, w); end
    end
    done = 1'b0;
    fork
      begin
        for (int v = 0; v < 25; v++) begin
          int len, rf;
          bit f0;
          len = $urandom_range(1, 6);
          rf  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 5)) : -1;
          f0  = ($urandom_range(0, 7) != 0);
          send_vec(len, f0, rf);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL bp_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL bp_model got=%h want=%h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [63:0] a, c;
    logic [19:0] s;
    int          w;
    res_t        o, e;
    send_beat(rnd64(), 20'($urandom), rnd64(), 1'b1, 1'b0, w);
    send_beat(rnd64(), 20'($urandom), rnd64(), 1'b0, 1'b0, w);
    rstn = 1'b0; #1;
    checks++;
    if ({in_ready, out_valid, out_len_err, out_data} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got rdy=%b vld=%b err=%b data=%h want all zero",
               in_ready, out_valid, out_len_err, out_data);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    obs_q.delete();
    c = rnd64(); c[15:0] = 16'd7;
    for (int i = 0; i < 4; i++) begin
      a = rnd64(); a[15:0] = 16'(i + 1);
      s = 20'($urandom); s[4:0] = 5'd2;
      send_beat(a, s, c, i == 0, i == 3, w);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data[15:0] !== 16'd27 || out_len_err !== 1'b0) begin
      failures++;
      $display("FAIL midreset_sum got vld=%b lane0=%h err=%b want vld=1 lane0=001b err=0",
               out_valid, out_data[15:0], out_len_err);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      failures++;
      $display("FAIL midreset_count got=%0d want=1 (model=%0d)", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL midreset_model got=%h want=%h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_a = '0; in_s = '0; in_c = '0; out_ready = 1'b1;
    test_reset();
    test_single();
    test_accumulate();
    test_len_err();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
